// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_alu
//  Description : Arithmetic responder on the alu_start/alu_done handshake.
//                ADD/SUB/reserved opcodes complete on the capture edge;
//                signed MUL/DIV iterate one bit per clock for WIDTH clocks
//                on operand magnitudes, then apply a sign fix-up.
//                A full 4-phase handshake is enforced: done is held until
//                start drops, so a lingering start never retriggers.
//  Ports       : clk             - clock, rising edge
//                reset           - asynchronous reset, active low
//                alu_start       - request, held until alu_done is seen
//                alu_opcode      - 000 ADD, 001 SUB, 010 MUL, 011 DIV, 1xx rsvd
//                alu_a / alu_b   - operands (dividend/multiplicand, divisor/multiplier)
//                alu_result_low  - sum/difference, product low word, quotient
//                alu_result_high - carry/borrow, product high word, remainder
//                alu_done        - result valid level
//                alu_busy        - iterative operation in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_start,
    input  logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_result_low,
    output logic [WIDTH-1:0] alu_result_high,
    output logic             alu_done,
    output logic             alu_busy
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;

    logic               r_is_div;
    logic               r_neg_a;
    logic               r_neg_b;
    logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] r_acc;      // MUL: {partial, multiplier}; DIV: {remainder, quotient}
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_res_lo;
    logic [WIDTH-1:0]   r_res_hi;

    logic               w_iter_op;
    logic               w_last;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_rem_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_acc_next;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_final;

    assign w_iter_op = (alu_opcode[2:1] == 2'b01);
    assign w_last    = (r_cnt == c_CNT_W'(1));

    assign w_abs_a = alu_a[WIDTH-1] ? -alu_a : alu_a;
    assign w_abs_b = alu_b[WIDTH-1] ? -alu_b : alu_b;
    assign w_add   = {1'b0, alu_a} + {1'b0, alu_b};
    assign w_sub   = {1'b0, alu_a} - {1'b0, alu_b};   // bit WIDTH is the borrow

    // Shift-add step: add multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole pair right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring division step: shift the next dividend bit into the
    // remainder, subtract the divisor when it fits, shift in the quotient bit.
    // The remainder stays below the divisor, so the kept value fits WIDTH bits.
    assign w_rem_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_rem_shift >= {1'b0, r_opnd});
    assign w_rem_diff  = w_rem_shift[WIDTH-1:0] - r_opnd;
    assign w_div_next  = {(w_div_ge ? w_rem_diff : w_rem_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};

    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

    // Sign fix-up on the final iteration's result. The remainder takes the
    // dividend's sign; a zero divisor forces an all-ones quotient while the
    // remainder naturally recovers the dividend.
    assign w_prod = (r_neg_a ^ r_neg_b) ? -w_acc_next : w_acc_next;
    assign w_quot = (r_opnd == '0)       ? {WIDTH{1'b1}} :
                    (r_neg_a ^ r_neg_b)  ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0];
    assign w_rem  = r_neg_a ? -w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[2*WIDTH-1:WIDTH];
    assign w_final = r_is_div ? {w_rem, w_quot} : w_prod;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (alu_start) begin
                    w_state_next = w_iter_op ? c_ST_BUSY : c_ST_DONE;
                end
            end
            c_ST_BUSY: begin
                if (w_last) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (!alu_start) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        alu_done        = (r_state == c_ST_DONE);
        alu_busy        = (r_state == c_ST_BUSY);
        alu_result_low  = r_res_lo;
        alu_result_high = r_res_hi;
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, iteration and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_res_lo <= '0;
            r_res_hi <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (alu_start) begin
                        r_is_div <= alu_opcode[0];
                        r_neg_a  <= alu_a[WIDTH-1];
                        r_neg_b  <= alu_b[WIDTH-1];
                        if (w_iter_op) begin
                            r_cnt <= c_CNT_W'(WIDTH);
                            if (alu_opcode[0]) begin
                                r_opnd <= w_abs_b;
                                r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                            end else begin
                                r_opnd <= w_abs_a;
                                r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                            end
                        end else if (alu_opcode[2]) begin
                            r_res_lo <= '0;
                            r_res_hi <= '0;
                        end else if (alu_opcode[0]) begin
                            r_res_lo <= w_sub[WIDTH-1:0];
                            r_res_hi <= WIDTH'(w_sub[WIDTH]);
                        end else begin
                            r_res_lo <= w_add[WIDTH-1:0];
                            r_res_hi <= WIDTH'(w_add[WIDTH]);
                        end
                    end
                end
                c_ST_BUSY: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (w_last) begin
                        r_res_lo <= w_final[WIDTH-1:0];
                        r_res_hi <= w_final[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_alu
//  Description : Self-checking bench for multicycle_alu: directed vector
//                table, randomized operations against an integer-arithmetic
//                reference model, handshake-hold and mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;

    logic        clk;
    logic        reset;
    logic        alu_start;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result_low;
    logic [15:0] alu_result_high;
    logic        alu_done;
    logic        alu_busy;

    int n_tests;
    int n_fail;

    multicycle_alu #(.WIDTH(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .alu_start       (alu_start),
        .alu_opcode      (alu_opcode),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_result_low  (alu_result_low),
        .alu_result_high (alu_result_high),
        .alu_done        (alu_done),
        .alu_busy        (alu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] lo;
        logic [15:0] hi;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain signed integer arithmetic on the operands.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        int sa;
        int sb;
        int q;
        int r;
        logic [31:0] res;
        sa = int'($signed(a));
        sb = int'($signed(b));
        res = 32'h0;
        if (op[2]) begin
            res = 32'h0;
        end else if (op == 3'd0) begin
            res = (int'(a) + int'(b) > 65535) ? 32'h1_0000 : 32'h0;
            res[15:0] = a + b;
        end else if (op == 3'd1) begin
            res[15:0]  = a - b;
            res[31:16] = (a < b) ? 16'd1 : 16'd0;
        end else if (op == 3'd2) begin
            res = sa * sb;
        end else if (b == 16'h0) begin
            res = {a, 16'hFFFF};
        end else begin
            q = sa / sb;
            r = sa % sb;
            res = {r[15:0], q[15:0]};
        end
        return res;
    endfunction

    function automatic int model_lat(input logic [2:0] op);
        return (op[2:1] == 2'b01) ? 16 : 0;
    endfunction

    // Run one full handshake: capture, wait for done, hold start for
    // 'hold' extra edges, then drop start and confirm done clears.
    task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_lo,
                          input logic [15:0] exp_hi, input int exp_lat, input int hold);
        int lat;
        int busy_cnt;
        @(negedge clk);
        alu_start  = 1'b1;
        alu_opcode = op;
        alu_a      = a;
        alu_b      = b;
        @(posedge clk); #1;
        lat = 0;
        busy_cnt = 0;
        while (!alu_done && lat < 40) begin
            if (alu_busy) busy_cnt++;
            // Operand changes while busy must have no effect.
            alu_a = 16'($urandom);
            alu_b = 16'($urandom);
            alu_opcode = 3'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy_cycles"}, busy_cnt, exp_lat);
        check({name, " result"}, {alu_result_high, alu_result_low}, {exp_hi, exp_lo});
        check({name, " busy_at_done"}, alu_busy, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, " hold_done"}, alu_done, 1'b1);
            check({name, " hold_result"}, {alu_result_high, alu_result_low}, {exp_hi, exp_lo});
        end
        @(negedge clk);
        alu_start = 1'b0;
        @(posedge clk); #1;
        check({name, " done_clear"}, alu_done, 1'b0);
        check({name, " result_after"}, {alu_result_high, alu_result_low}, {exp_hi, exp_lo});
    endtask

    vec_t vecs[$];

    initial begin
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
        int          ccount;

        n_tests = 0;
        n_fail  = 0;
        reset      = 1'b0;
        alu_start  = 1'b0;
        alu_opcode = 3'd0;
        alu_a      = 16'h0;
        alu_b      = 16'h0;

        vecs.push_back('{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 0});
        vecs.push_back('{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0001, 0});
        vecs.push_back('{3'd2, 16'hFFFD, 16'h0007, 16'hFFEB, 16'hFFFF, 16});
        vecs.push_back('{3'd3, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 16});
        vecs.push_back('{3'd3, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 16});
        vecs.push_back('{3'd3, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 16});
        vecs.push_back('{3'd5, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 0});
        vecs.push_back('{3'd2, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 16});
        vecs.push_back('{3'd3, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 16});
        vecs.push_back('{3'd0, 16'h1234, 16'h4321, 16'h5555, 16'h0000, 0});

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {alu_result_high, alu_result_low, 14'h0, alu_done, alu_busy},
              48'h0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].lo, vecs[i].hi, vecs[i].lat, (i == 2) ? 5 : 0);
        end

        // Start held 5 edges past done on a single-cycle op: no retrigger.
        run_op("hold_add", 3'd0, 16'h0010, 16'h0020, 16'h0030, 16'h0000, 0, 5);

        // Reset in the middle of a multiply.
        @(negedge clk);
        alu_start  = 1'b1;
        alu_opcode = 3'd2;
        alu_a      = 16'h1234;
        alu_b      = 16'h5678;
        @(posedge clk); #1;
        check("mul_busy_after_capture", alu_busy, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midreset_outputs", {alu_result_high, alu_result_low, 14'h0, alu_done, alu_busy},
              48'h0);
        alu_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_op("post_reset_add", 3'd0, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 0, 0);

        // Randomized operations against the reference model.
        ccount = 0;
        for (int i = 0; i < 120; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 16'h8000;
                1: a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 6))
                0: b = 16'h0000;
                1: b = 16'hFFFF;
                2: b = 16'h8000;
                default: b = 16'($urandom);
            endcase
            exp = model(op, a, b);
            run_op($sformatf("rand%0d op%0d a=%h b=%h", i, op, a, b), op, a, b,
                   exp[15:0], exp[31:16], model_lat(op), i % 3);
            ccount++;
        end
        check("random_ops_run", ccount, 120);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
